// File: rtl/apb_spi_master_ctrl.sv
// APB3 slave that sequences 16-bit SPI master transfers (CPHA=0, MSB first).
// Defining APB_SPI_IRQ_EN adds a stored CTRL.IRQ_EN bit and a registered irq output.
module apb_spi_master_ctrl #(
    parameter int         DATA_W  = 16,
    parameter logic [7:0] DIV_RST = 8'd3
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [3:0]        PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SS_n
`ifdef APB_SPI_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int              HP_W    = $clog2(2*DATA_W);
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(2*DATA_W-1);

    typedef enum logic [1:0] {IDLE, ASSERT, SHIFT, RELEASE} state_t;
    state_t state, state_nxt;

    logic [7:0]        div, cnt;
    logic              cpol, done, irq_en_q;
    logic [DATA_W-1:0] txdata, rxdata, tx_sh, rx_sh;
    logic [HP_W-1:0]   hp;
    logic [1:0]        sel;
    logic              access, busy, tc, load_cnt, set_done;
    logic              wr_ctrl, wr_tx, rd_rx, start;
    logic              unused;

    assign sel     = PADDR[3:2];
    assign access  = PSEL & PENABLE;
    assign busy    = (state != IDLE);
    assign tc      = (cnt == 8'd0);
    assign wr_ctrl = access & PWRITE & (sel == 2'd0) & ~busy;
    assign wr_tx   = access & PWRITE & (sel == 2'd2) & ~busy;
    assign rd_rx   = access & ~PWRITE & (sel == 2'd3);
    assign start   = wr_ctrl & PWDATA[9];
    assign PREADY  = 1'b1;
    // STATUS/RXDATA (sel[0]=1) are never writable; CTRL/TXDATA reject writes while busy
    assign PSLVERR = access & PWRITE & (sel[0] | busy);
    assign unused  = ^{PADDR[1:0], PWDATA[DATA_W-1:10]};

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_cnt  = 1'b0;
        set_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ASSERT;
                    load_cnt  = 1'b1;
                end
            end
            ASSERT: begin
                if (tc) begin
                    state_nxt = SHIFT;
                    load_cnt  = 1'b1;
                end
            end
            SHIFT: begin
                if (tc) begin
                    load_cnt = 1'b1;
                    if (hp == HP_LAST) state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (tc) begin
                    state_nxt = IDLE;
                    set_done  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            div    <= DIV_RST;
            cpol   <= 1'b0;
            txdata <= '0;
            rxdata <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            hp     <= '0;
            tx_sh  <= '0;
            rx_sh  <= '0;
            SCLK   <= 1'b0;
            MOSI   <= 1'b0;
            SS_n   <= 1'b1;
        end else begin
            if (wr_ctrl) begin
                div  <= PWDATA[7:0];
                cpol <= PWDATA[8];
            end
            if (wr_tx) txdata <= PWDATA;

            if (set_done)   done <= 1'b1;
            else if (rd_rx) done <= 1'b0;

            // the START write may carry a new DIV, so the first load takes it from PWDATA
            if (load_cnt)  cnt <= start ? PWDATA[7:0] : div;
            else if (!tc)  cnt <= cnt - 8'd1;

            case (state)
                IDLE: begin
                    SCLK <= start ? PWDATA[8] : cpol;
                    if (start) begin
                        tx_sh <= txdata;
                        MOSI  <= txdata[DATA_W-1];
                        SS_n  <= 1'b0;
                        hp    <= '0;
                    end
                end
                SHIFT: begin
                    if (tc) begin
                        SCLK <= ~SCLK;
                        hp   <= hp + HP_W'(1);
                        if (!hp[0]) begin
                            rx_sh <= {rx_sh[DATA_W-2:0], MISO};
                        end else begin
                            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                            MOSI  <= tx_sh[DATA_W-2];
                        end
                    end
                end
                RELEASE: begin
                    SCLK <= cpol;
                    if (tc) begin
                        SS_n   <= 1'b1;
                        rxdata <= rx_sh;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef APB_SPI_IRQ_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en_q <= PWDATA[10];
            irq <= done & irq_en_q;
        end
    end
`else
    assign irq_en_q = 1'b0;
`endif

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (sel)
                2'd0: PRDATA[10:0] = {irq_en_q, 1'b0, cpol, div};
                2'd1: PRDATA[1:0]  = {done, busy};
                2'd2: PRDATA       = txdata;
                // a read racing the DONE set returns the word being committed
                default: PRDATA    = set_done ? rx_sh : rxdata;
            endcase
        end
    end

endmodule

// File: doc/apb_spi_master_ctrl.md
Name: apb_spi_master_ctrl

Overview:
APB3 slave that owns a 16-bit SPI master and sequences each transfer. Software sets clock divider and polarity, loads TX data and writes START. The block drives SS_n, SCLK and MOSI, captures MISO into RXDATA and raises a sticky DONE flag. It sits between the APB fabric and the external SPI pins.

Parameters:
DATA_W, 16, SPI word width and APB data width; MSB first.
DIV_RST, 8'd3, reset value of CTRL.DIV.

Ports:
PCLK  in  1  single system clock; all logic is rising-edge.
PRESET  in  1  asynchronous, active-high reset.
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1 = write.
PADDR  in  4  byte address; PADDR[3:2] selects the register.
PWDATA  in  16  write data.
PRDATA  out  16  read data.
PREADY  out  1  tied 1; no wait states.
PSLVERR  out  1  error response.
SCLK  out  1  SPI clock.
MOSI  out  1  SPI data out.
MISO  in  1  SPI data in; synchronous to SCLK, no extra synchroniser.
SS_n  out  1  slave select, active low.

Behaviour:
- Register map, by PADDR[3:2]:
  - 0 CTRL: [7:0] DIV, [8] CPOL, [9] START (write-1 pulse, reads 0), [10] IRQ_EN.
  - 1 STATUS: [0] BUSY, [1] DONE; read-only.
  - 2 TXDATA: read/write.
  - 3 RXDATA: read-only; a read clears DONE.
- Register side effects occur only in the access phase (PSEL & PENABLE).
- PRDATA is a combinational mux when PSEL & !PWRITE; it is 0 otherwise.
- PSLVERR is asserted only in the access phase when:
  - writing CTRL or TXDATA while BUSY (write discarded), or
  - writing STATUS or RXDATA (write ignored).
- Reset values: SS_n=1, SCLK=0, MOSI=0, PSLVERR=0, PRDATA=0; all registers 0 except DIV=DIV_RST; FSM in IDLE.
- Half-period H = DIV+1 PCLK cycles, set by a down-counter. DIV=0 gives H=1.
- FSM states: IDLE, ASSERT, SHIFT, RELEASE.
  - IDLE: SS_n=1, SCLK=CPOL. A START write latches TXDATA into the shift register and goes to ASSERT on the next edge; BUSY=1 from that edge.
  - ASSERT: SS_n=0, MOSI=shift[15], lasts H cycles, then SHIFT.
  - SHIFT: 32 half-periods with SCLK toggling at each half-period end (mode CPHA=0).
    - Leading edge: sample MISO into the rx shift register.
    - Trailing edge: shift tx left; MOSI = next bit.
    - After the 16th trailing edge, go to RELEASE.
  - RELEASE: SCLK=CPOL, SS_n=0 for H cycles, then SS_n=1. Load RXDATA, set DONE, clear BUSY, go to IDLE.
- Timing: BUSY high to DONE set = 34*H cycles exactly.
- DONE set and an RXDATA read in the same cycle: set wins; the read returns the new data.
- START while BUSY is an error (PSLVERR) with no effect on the transfer in progress.
- Reset mid-transfer: outputs return to reset values immediately (asynchronous); no DONE; RXDATA=0.

Optional Feature:
APB_SPI_IRQ_EN:
- Defined: adds output port irq (1 bit) = DONE & IRQ_EN, registered, reset 0.
- Undefined: no irq port; CTRL[10] is not stored and reads 0.

Test Plan:
1. Assert PRESET mid-cycle -> SS_n=1, SCLK=0, MOSI=0; read CTRL=0x0003, STATUS=0x0000.
2. Loopback MISO=MOSI; TXDATA=0xA5C3; CTRL=0x0201 (DIV=1, START) -> BUSY next cycle, 16 SCLK pulses of period 4; DONE exactly 68 cycles after BUSY; RXDATA=0xA5C3; DONE reads 0 after the RXDATA read.
3. Slave model returns 0x1234; CTRL=0x0300 (CPOL=1, DIV=0, START) -> SCLK idles high, MISO sampled on falling edges, RXDATA=0x1234, 34 cycles.
4. While BUSY: write TXDATA=0xFFFF, write CTRL START -> PSLVERR=1 on both; transfer completes with the original data; TXDATA unchanged.
5. Assert PRESET after the 7th SCLK edge -> SS_n=1 and SCLK=0 immediately; after release, STATUS=0 and RXDATA=0.
6. With APB_SPI_IRQ_EN: IRQ_EN=1, complete a transfer -> irq=1 one cycle after DONE; RXDATA read -> irq=0 on the next cycle.
